fft_peak_detect: RTL and testbench

//  Sits directly downstream of the xfft_0 master data stream in the clk_1_6384m domain.

---
 rtl/fft_peak_detect.sv | 201 ++++++++++++++++++++
 tb/tb_fft_peak_detect.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_detect.sv
// fft_peak_detect
//   Watches the FFT master data stream and finds the strongest bin in
//   [BIN_LO, BIN_HI] over one armed frame. The magnitude of each bin is
//   approximated as |X| ~= max(|re|,|im|) + min(|re|,|im|)/2.
//
// Ports
//   clk           single clock
//   rst           synchronous, active-high reset
//   start         1-cycle arm pulse, honoured only in IDLE
//   s_tvalid      FFT output beat valid (no backpressure)
//   s_real/s_imag bin real / imaginary part, signed
//   s_index       bin index of this beat
//   s_blk_exp     FFT block exponent for this frame
//   busy          high while waiting for start-of-frame or accumulating
//   peak_valid    1-cycle pulse when the result outputs are updated
//   peak_index    bin with the largest magnitude
//   peak_mag      approximate magnitude of that bin, unsigned
//   peak_blk_exp  block exponent captured with the frame's last beat
//   frame_err     1-cycle pulse on an index discontinuity
module fft_peak_detect #(
  parameter int N_FFT  = 4096,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 16,
  parameter int BIN_LO = 1,
  parameter int BIN_HI = 2047
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     s_tvalid,
  input  logic signed [DATA_W-1:0] s_real,
  input  logic signed [DATA_W-1:0] s_imag,
  input  logic [IDX_W-1:0]         s_index,
  input  logic [7:0]               s_blk_exp,
  output logic                     busy,
  output logic                     peak_valid,
  output logic [IDX_W-1:0]         peak_index,
  output logic [DATA_W-1:0]        peak_mag,
  output logic [7:0]               peak_blk_exp,
  output logic                     frame_err
);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACC, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FFT - 1);
  localparam logic [IDX_W-1:0] LO_IDX   = IDX_W'(BIN_LO);
  localparam logic [IDX_W-1:0] HI_IDX   = IDX_W'(BIN_HI);

  // ---------------------------------------------------------------------
  // Magnitude pipeline (runs on every beat, independent of the FSM)
  // ---------------------------------------------------------------------
  // Negating the most negative value wraps to itself, whose unsigned
  // reading is exactly the wanted absolute value.
  logic [DATA_W-1:0] re_abs, im_abs;
  assign re_abs = s_real[DATA_W-1] ? unsigned'(-s_real) : unsigned'(s_real);
  assign im_abs = s_imag[DATA_W-1] ? unsigned'(-s_imag) : unsigned'(s_imag);

  logic              p1_vld_q, p2_vld_q;
  logic [DATA_W-1:0] p1_a_q, p1_b_q, p2_mag_q;
  logic [IDX_W-1:0]  p1_idx_q, p2_idx_q;
  logic [7:0]        p1_exp_q, p2_exp_q;
  logic [DATA_W-1:0] mag_d;

  // max + min/2 peaks at 32768 + 16384, which still fits DATA_W unsigned.
  assign mag_d = (p1_a_q >= p1_b_q) ? p1_a_q + (p1_b_q >> 1)
                                    : p1_b_q + (p1_a_q >> 1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_vld_q <= 1'b0;
      p1_a_q   <= '0;
      p1_b_q   <= '0;
      p1_idx_q <= '0;
      p1_exp_q <= '0;
      p2_vld_q <= 1'b0;
      p2_mag_q <= '0;
      p2_idx_q <= '0;
      p2_exp_q <= '0;
    end else begin
      p1_vld_q <= s_tvalid;
      p1_a_q   <= re_abs;
      p1_b_q   <= im_abs;
      p1_idx_q <= s_index;
      p1_exp_q <= s_blk_exp;
      p2_vld_q <= p1_vld_q;
      p2_mag_q <= mag_d;
      p2_idx_q <= p1_idx_q;
      p2_exp_q <= p1_exp_q;
    end
  end

  // ---------------------------------------------------------------------
  // Frame FSM, fed from the end of the magnitude pipeline
  // ---------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [DATA_W-1:0] best_mag_q, best_mag_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic [IDX_W-1:0]  exp_idx_q, exp_idx_d;
  logic              peak_valid_q, peak_valid_d;
  logic              frame_err_q, frame_err_d;
  logic [IDX_W-1:0]  peak_index_q, peak_index_d;
  logic [DATA_W-1:0] peak_mag_q, peak_mag_d;
  logic [7:0]        peak_blk_exp_q, peak_blk_exp_d;
  logic              in_range;

  assign in_range = (p2_idx_q >= LO_IDX) && (p2_idx_q <= HI_IDX);

  // NOTE: every variable gets a default at the top of always_comb, so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_d        = state_q;
    best_mag_d     = best_mag_q;
    best_idx_d     = best_idx_q;
    exp_idx_d      = exp_idx_q;
    peak_valid_d   = 1'b0;
    frame_err_d    = 1'b0;
    peak_index_d   = peak_index_q;
    peak_mag_d     = peak_mag_q;
    peak_blk_exp_d = peak_blk_exp_q;

    unique case (state_q)
      IDLE: begin
        if (start) state_d = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (p2_vld_q && p2_idx_q == '0) begin
          state_d    = ACC;
          best_mag_d = '0;
          best_idx_d = LO_IDX;
          exp_idx_d  = IDX_W'(1);
          // Only matters when the search range includes DC.
          if (in_range && p2_mag_q != '0) begin
            best_mag_d = p2_mag_q;
            best_idx_d = p2_idx_q;
          end
        end
      end
      ACC: begin
        if (p2_vld_q) begin
          if (p2_idx_q != exp_idx_q) begin
            // Partial result is dropped; this beat cannot open a new frame.
            frame_err_d = 1'b1;
            state_d     = WAIT_SOF;
          end else begin
            exp_idx_d = p2_idx_q + 1'b1;
            // Strict compare keeps the lower index on ties.
            if (in_range && p2_mag_q > best_mag_q) begin
              best_mag_d = p2_mag_q;
              best_idx_d = p2_idx_q;
            end
            if (p2_idx_q == LAST_IDX) begin
              peak_blk_exp_d = p2_exp_q;
              state_d        = DONE;
            end
          end
        end
      end
      DONE: begin
        peak_valid_d = 1'b1;
        peak_index_d = best_idx_q;
        peak_mag_d   = best_mag_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      best_mag_q     <= '0;
      best_idx_q     <= '0;
      exp_idx_q      <= '0;
      peak_valid_q   <= 1'b0;
      frame_err_q    <= 1'b0;
      peak_index_q   <= '0;
      peak_mag_q     <= '0;
      peak_blk_exp_q <= '0;
    end else begin
      state_q        <= state_d;
      best_mag_q     <= best_mag_d;
      best_idx_q     <= best_idx_d;
      exp_idx_q      <= exp_idx_d;
      peak_valid_q   <= peak_valid_d;
      frame_err_q    <= frame_err_d;
      peak_index_q   <= peak_index_d;
      peak_mag_q     <= peak_mag_d;
      peak_blk_exp_q <= peak_blk_exp_d;
    end
  end

  assign busy         = (state_q == WAIT_SOF) || (state_q == ACC);
  assign peak_valid   = peak_valid_q;
  assign frame_err    = frame_err_q;
  assign peak_index   = peak_index_q;
  assign peak_mag     = peak_mag_q;
  assign peak_blk_exp = peak_blk_exp_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect with a small frame (64 bins, search
// range 1..31). Expected results are queued when a frame is driven and
// compared when peak_valid appears.
module tb_fft_peak_detect;

  localparam int N  = 64;
  localparam int LO = 1;
  localparam int HI = 31;

  logic               clk = 1'b0;
  logic               rst, start, s_tvalid;
  logic signed [15:0] s_real, s_imag;
  logic [15:0]        s_index;
  logic [7:0]         s_blk_exp;
  logic               busy, peak_valid, frame_err;
  logic [15:0]        peak_index, peak_mag;
  logic [7:0]         peak_blk_exp;

  fft_peak_detect #(
    .N_FFT (N),
    .DATA_W(16),
    .IDX_W (16),
    .BIN_LO(LO),
    .BIN_HI(HI)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .s_tvalid    (s_tvalid),
    .s_real      (s_real),
    .s_imag      (s_imag),
    .s_index     (s_index),
    .s_blk_exp   (s_blk_exp),
    .busy        (busy),
    .peak_valid  (peak_valid),
    .peak_index  (peak_index),
    .peak_mag    (peak_mag),
    .peak_blk_exp(peak_blk_exp),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int mag;
    int bexp;
  } result_t;

  result_t sb[$];
  int      n_tests  = 0;
  int      n_fail   = 0;
  int      pv_count = 0;
  int      fre[N];
  int      fim[N];

  // Counts every result pulse so that unexpected ones can be detected.
  always @(posedge clk) if (peak_valid === 1'b1) pv_count <= pv_count + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mag_of(input int re, input int im);
    int a, b;
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
    return (a > b) ? a + b / 2 : b + a / 2;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input int re, input int im, input int idx, input logic [7:0] bexp);
    s_tvalid  = 1'b1;
    s_real    = 16'(re);
    s_imag    = 16'(im);
    s_index   = 16'(idx);
    s_blk_exp = bexp;
    @(posedge clk);
    #1;
    s_tvalid  = 1'b0;
  endtask

  task automatic send_frame(input int first, input int last, input logic [7:0] bexp, input bit gaps);
    for (int i = first; i <= last; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      send_beat(fre[i], fim[i], i, bexp);
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < N; i++) begin
      fre[i] = 0;
      fim[i] = 0;
    end
  endtask

  task automatic random_frame();
    for (int i = 0; i < N; i++) begin
      fre[i] = int'($urandom_range(0, 8000)) - 4000;
      fim[i] = int'($urandom_range(0, 8000)) - 4000;
    end
  endtask

  task automatic push_const(input int idx, input int mag, input int bexp);
    result_t r;
    r.idx  = idx;
    r.mag  = mag;
    r.bexp = bexp;
    sb.push_back(r);
  endtask

  task automatic push_model(input int bexp);
    result_t r;
    int m;
    r.idx  = LO;
    r.mag  = 0;
    r.bexp = bexp;
    for (int i = LO; i <= HI; i++) begin
      m = mag_of(fre[i], fim[i]);
      if (m > r.mag) begin
        r.mag = m;
        r.idx = i;
      end
    end
    sb.push_back(r);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called right after the edge that accepted the last beat: the result
  // must show up on the third edge and last exactly one cycle.
  task automatic check_result(input string tag);
    result_t r;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s.valid_at_%0d", tag, k), {31'd0, peak_valid}, (k == 3) ? 32'd1 : 32'd0);
    end
    check({tag, ".sb_has_entry"}, sb.size(), 1);
    if (sb.size() > 0) begin
      r = sb.pop_front();
      check({tag, ".index"}, {16'd0, peak_index}, r.idx);
      check({tag, ".mag"}, {16'd0, peak_mag}, r.mag);
      check({tag, ".blk_exp"}, {24'd0, peak_blk_exp}, r.bexp);
    end
    @(posedge clk);
    #1;
    check({tag, ".valid_drops"}, {31'd0, peak_valid}, 0);
    check({tag, ".busy_after"}, {31'd0, busy}, 0);
  endtask

  initial begin
    int pv0;
    rst = 1'b1; start = 1'b0; s_tvalid = 1'b0;
    s_real = '0; s_imag = '0; s_index = '0; s_blk_exp = '0;
    idle(3);
    rst = 1'b0;
    idle(1);
    check("rst.busy", {31'd0, busy}, 0);
    check("rst.peak_valid", {31'd0, peak_valid}, 0);
    check("rst.frame_err", {31'd0, frame_err}, 0);
    check("rst.peak_index", {16'd0, peak_index}, 0);
    check("rst.peak_mag", {16'd0, peak_mag}, 0);
    check("rst.peak_blk_exp", {24'd0, peak_blk_exp}, 0);

    // 1. single tone in bin 10
    clear_frame();
    fre[10] = 300; fim[10] = -400;
    pulse_start();
    check("t1.busy", {31'd0, busy}, 1);
    push_const(10, 550, 5);
    send_frame(0, N - 1, 8'd5, 1'b0);
    check_result("t1");

    // 2. tie between bins 5 and 20; DC and out-of-range bin are larger
    clear_frame();
    fre[5] = 1000; fre[20] = 1000; fre[0] = 32767; fre[40] = 20000;
    pulse_start();
    push_const(5, 1000, 6);
    send_frame(0, N - 1, 8'd6, 1'b0);
    check_result("t2");

    // 3. full-scale negative corner
    clear_frame();
    fre[7] = -32768; fim[7] = -32768;
    pulse_start();
    push_const(7, 49152, 7);
    send_frame(0, N - 1, 8'd7, 1'b0);
    check_result("t3");

    // 4. index jump 12 -> 14, then a clean frame without a new start
    clear_frame();
    fre[3] = 500;
    pulse_start();
    send_frame(0, 12, 8'd9, 1'b0);
    send_beat(0, 0, 14, 8'd9);
    idle(1);
    check("t4.err_not_yet", {31'd0, frame_err}, 0);
    idle(1);
    check("t4.frame_err", {31'd0, frame_err}, 1);
    check("t4.busy_held", {31'd0, busy}, 1);
    idle(1);
    check("t4.err_pulse_ends", {31'd0, frame_err}, 0);
    clear_frame();
    fre[25] = -700; fim[25] = 100;
    push_const(25, 750, 9);
    send_frame(0, N - 1, 8'd9, 1'b0);
    check_result("t4");

    // 5. reset in the middle of a frame
    clear_frame();
    fre[20] = 2000;
    pulse_start();
    send_frame(0, 30, 8'd4, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("t5.busy", {31'd0, busy}, 0);
    check("t5.peak_valid", {31'd0, peak_valid}, 0);
    check("t5.frame_err", {31'd0, frame_err}, 0);
    check("t5.peak_index", {16'd0, peak_index}, 0);
    check("t5.peak_mag", {16'd0, peak_mag}, 0);
    check("t5.peak_blk_exp", {24'd0, peak_blk_exp}, 0);
    pv0 = pv_count;
    send_frame(31, N - 1, 8'd4, 1'b0);
    send_frame(0, N - 1, 8'd4, 1'b0);
    idle(5);
    check("t5.no_result", pv_count, pv0);
    check("t5.idle", {31'd0, busy}, 0);

    // 6. gapped frame without start is ignored, then a gapped armed frame
    random_frame();
    pv0 = pv_count;
    send_frame(0, N - 1, 8'd3, 1'b1);
    idle(5);
    check("t6.no_start_no_result", pv_count, pv0);
    check("t6.no_start_idle", {31'd0, busy}, 0);
    random_frame();
    pulse_start();
    push_model(3);
    send_frame(0, N - 1, 8'd3, 1'b1);
    check_result("t6");
    check("t6.sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
